axi_write_vector: RTL

- Serialises one bit-vector of runtime length `vec_length` onto an AXI-stream master as ceil(vec_length / AXI_DATA_WIDTH) beats.
- Transmit-side counterpart of `axi_read_vector`, using the same direction and framing rules so the two can be connected back to back.
- Used by producers of candidate-solution streams and by benches that feed solution readers.
- `tlast` marks the final beat of the final vector of a set, which is what the reader reports as `last`.

---
 rtl/axi_write_vector_pkg.sv | 14 +
 rtl/axi_write_vector_if.sv | 16 +
 rtl/axi_write_vector.sv | 121 ++++++++++++
 3 files changed

// File: rtl/axi_write_vector_pkg.sv
// Shared types for the axi_read_vector / axi_write_vector pair: element-order enum and beat-count helper.
package axi_write_vector_pkg;

  typedef enum logic {
    DIR__LEFT,
    DIR__RIGHT
  } dir_t;

  // A zero-length vector still occupies one beat so stream framing is preserved.
  function automatic int beat_count(input int len, input int w);
    return (len <= 0) ? 1 : (len + w - 1) / w;
  endfunction

endpackage

// File: rtl/axi_write_vector_if.sv
// AXI-stream bundle (tvalid/tready/tdata/tlast) with master and slave views.
interface axi_stream_if
  import axi_write_vector_pkg::*;
#(
  parameter int W = 8
) ();
  // A beat transfers on a rising clk edge where tvalid && tready; once tvalid
  // rises, tvalid/tdata/tlast hold until that handshake, and tready may toggle freely.
  logic         tvalid;
  logic         tready;
  logic [W-1:0] tdata;
  logic         tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/axi_write_vector.sv
// Serialises one runtime-length bit vector into ceil(len/W) AXI-stream beats.
// Optional macro AXI_WRITE_VECTOR_BACK_TO_BACK_EN: accept the next vector during the final beat (no bubble).
module axi_write_vector
  import axi_write_vector_pkg::*;
#(
  parameter int   MAX_VEC_LENGTH   = 8,
  parameter int   AXI_DATA_WIDTH   = 8,
  parameter dir_t WRITE_DIR        = DIR__LEFT,
  parameter int   MAX_VEC_LENGTH_W = ($clog2(MAX_VEC_LENGTH + 1) < 1) ? 1 : $clog2(MAX_VEC_LENGTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [MAX_VEC_LENGTH_W-1:0] vec_length,
  input  logic [MAX_VEC_LENGTH-1:0]   vec,
  input  logic                        last,
  output logic                        ready,
  output logic                        done,
  axi_stream_if.master                data_out
);

  localparam int W         = AXI_DATA_WIDTH;
  localparam int MAX_BEATS = beat_count(MAX_VEC_LENGTH, W);
  localparam int SR_W      = MAX_BEATS * W;
  localparam int BEAT_W    = ($clog2(MAX_BEATS + 1) < 1) ? 1 : $clog2(MAX_BEATS + 1);

  typedef enum logic {
    WV_STATE__IDLE,
    WV_STATE__SEND
  } wv_state_e;

  wv_state_e           state_q, state_d;
  logic [SR_W-1:0]     shift_q, shift_d;
  logic [BEAT_W-1:0]   beats_q, beats_d;
  logic                last_q, last_d;
  logic                done_q, done_d;

  logic [MAX_VEC_LENGTH-1:0] masked;
  logic [SR_W-1:0]           load_shift;
  logic [BEAT_W-1:0]         load_beats;
  logic                      final_beat;
  logic                      final_hs;
  logic                      accept;

  always_comb begin
    masked = '0;
    for (int i = 0; i < MAX_VEC_LENGTH; i++) begin
      masked[i] = vec[i] & (i < int'(vec_length));
    end
  end

  // LEFT puts element len-1 at the register MSB so the earliest element leaves on tdata[W-1].
  always_comb begin
    if (WRITE_DIR == DIR__LEFT) begin
      load_shift = SR_W'(masked) << (SR_W - int'(vec_length));
    end else begin
      load_shift = SR_W'(masked);
    end
    load_beats = BEAT_W'(beat_count(int'(vec_length), W));
  end

  assign final_beat = (beats_q == BEAT_W'(1));
  assign final_hs   = (state_q == WV_STATE__SEND) && data_out.tready && final_beat;

`ifdef AXI_WRITE_VECTOR_BACK_TO_BACK_EN
  assign ready = (state_q == WV_STATE__IDLE) || final_hs;
`else
  assign ready = (state_q == WV_STATE__IDLE);
`endif

  assign accept = start && ready;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    beats_d = beats_q;
    last_d  = last_q;
    done_d  = 1'b0;
    if (state_q == WV_STATE__SEND && data_out.tready) begin
      if (WRITE_DIR == DIR__LEFT) begin
        shift_d = shift_q << W;
      end else begin
        shift_d = shift_q >> W;
      end
      beats_d = beats_q - BEAT_W'(1);
      if (final_beat) begin
        done_d  = 1'b1;
        state_d = WV_STATE__IDLE;
      end
    end
    // In SEND, accept can only fire on the final handshake (back-to-back build).
    if (accept) begin
      shift_d = load_shift;
      beats_d = load_beats;
      last_d  = last;
      state_d = WV_STATE__SEND;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= WV_STATE__IDLE;
      shift_q <= '0;
      beats_q <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      beats_q <= beats_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  assign done            = done_q;
  assign data_out.tvalid = (state_q == WV_STATE__SEND);
  assign data_out.tlast  = (state_q == WV_STATE__SEND) && last_q && final_beat;
  assign data_out.tdata  = (WRITE_DIR == DIR__LEFT) ? shift_q[SR_W-1 -: W] : shift_q[W-1:0];

endmodule
